// File: rtl/rubik_pkg.sv
// Shared move codes, FSM state types and constants for the cube move scheduler.
package rubik_pkg;
  localparam int          MOVE_W    = 4;
  localparam int          NUM_MOVES = 12;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  typedef enum logic [MOVE_W-1:0] {
    MV_R = 4'd0, MV_RP, MV_L, MV_LP, MV_F, MV_FP,
    MV_B, MV_BP, MV_U, MV_UP, MV_D, MV_DP
  } move_t;

  typedef enum logic [1:0] {M_IDLE, M_SHUFFLE, M_SOLVE} mode_t;
  typedef enum logic [1:0] {E_READY, E_HOLD, E_GAP} eng_t;
endpackage

// File: rtl/move_fifo.sv
// Count-based FIFO; a write is accepted while full when a read frees the slot in the same cycle.
module move_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             wr_ready
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp, rp;
  logic [AW:0]      count;
  logic             full, do_wr, do_rd;

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign wr_ready = !full || rd_en;
  assign do_rd    = rd_en && !empty;
  assign do_wr    = wr_en && wr_ready;
  assign rd_data  = mem[rp];

  always_ff @(posedge clk)
    if (do_wr) mem[wp] <= wr_data;

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_wr) wp <= nxt(wp);
      if (do_rd) rp <= nxt(rp);
      case ({do_wr, do_rd})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
endmodule

// File: rtl/move_scheduler.sv
// Sequences one-hot motor moves from an LFSR shuffle source or a queued solver stream.
module move_scheduler
  import rubik_pkg::*;
#(
  parameter int MOVE_HOLD   = 4,
  parameter int MOVE_GAP    = 8,
  parameter int SHUFFLE_LEN = 20,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_shuffle,
  input  logic        btn_solve,
  input  logic        sol_valid,
  input  logic [3:0]  sol_move,
  output logic        sol_ready,
  output logic [11:0] move_out,
  output logic        shuffle,
  output logic        retain,
  output logic        busy,
  output logic [7:0]  move_cnt,
  output logic        err
);
  localparam logic [7:0] HOLD_LAST = 8'(MOVE_HOLD - 1);
  localparam logic [7:0] GAP_LAST  = 8'(MOVE_GAP - 1);
  localparam logic [7:0] SH_LEN    = 8'(SHUFFLE_LEN);

  mode_t       mode, mode_nx;
  eng_t        eng, eng_nx;
  logic [7:0]  tmr, tmr_nx, cnt_nx;
  logic [11:0] mv_nx;
  logic [15:0] lfsr;
  logic [3:0]  prev_sh, prev_sh_nx, raw, sh_code, code, fifo_q;
  logic        retain_nx, push, pop, fifo_wr, fifo_empty, fifo_ready;

  assign push      = sol_valid && sol_ready;
  assign fifo_wr   = push && (sol_move < 4'd12);
  assign sol_ready = fifo_ready && (mode != M_SHUFFLE);
  assign shuffle   = (mode == M_SHUFFLE);
  assign busy      = (mode != M_IDLE);

  move_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(MOVE_W)) u_fifo (
    .clk(clk), .reset(reset), .wr_en(fifo_wr), .wr_data(sol_move),
    .rd_en(pop), .rd_data(fifo_q), .empty(fifo_empty), .wr_ready(fifo_ready)
  );

  // Fold 12..15 onto 8..11, then dodge an immediate undo of the previous shuffle move.
  assign raw     = (lfsr[3:0] < 4'd12) ? lfsr[3:0] : lfsr[3:0] - 4'd4;
  assign sh_code = (raw != (prev_sh ^ 4'd1)) ? raw :
                   (raw >= 4'd10) ? raw - 4'd10 : raw + 4'd2;

  always_comb begin
    mode_nx    = mode;
    eng_nx     = eng;
    tmr_nx     = tmr;
    cnt_nx     = move_cnt;
    mv_nx      = move_out;
    prev_sh_nx = prev_sh;
    retain_nx  = 1'b0;
    pop        = 1'b0;
    code       = sh_code;

    case (mode)
      M_IDLE:
        if (btn_shuffle) begin
          mode_nx = M_SHUFFLE;
          cnt_nx  = '0;
        end else if (btn_solve) begin
          mode_nx = M_SOLVE;
          cnt_nx  = '0;
        end
      M_SHUFFLE:
        if (eng == E_READY && move_cnt == SH_LEN) begin
          mode_nx   = M_IDLE;
          retain_nx = 1'b1;
        end
      M_SOLVE:
        if (eng == E_READY && fifo_empty) begin
          mode_nx   = M_IDLE;
          retain_nx = 1'b1;
        end
      default: mode_nx = M_IDLE;
    endcase

    case (eng)
      E_READY: begin
        if (mode == M_SHUFFLE && move_cnt != SH_LEN) begin
          eng_nx     = E_HOLD;
          prev_sh_nx = sh_code;
        end else if (mode == M_SOLVE && !fifo_empty) begin
          eng_nx = E_HOLD;
          pop    = 1'b1;
          code   = fifo_q;
        end
        if (eng_nx == E_HOLD) begin
          tmr_nx = HOLD_LAST;
          mv_nx  = 12'd1 << code;
          cnt_nx = (move_cnt == 8'hFF) ? move_cnt : move_cnt + 8'd1;
        end
      end
      E_HOLD:
        if (tmr == '0) begin
          eng_nx = E_GAP;
          tmr_nx = GAP_LAST;
          mv_nx  = '0;
        end else tmr_nx = tmr - 8'd1;
      E_GAP:
        if (tmr == '0) eng_nx = E_READY;
        else tmr_nx = tmr - 8'd1;
      default: eng_nx = E_READY;
    endcase
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      mode     <= M_IDLE;
      eng      <= E_READY;
      tmr      <= '0;
      move_cnt <= '0;
      move_out <= '0;
      prev_sh  <= 4'hF;
      retain   <= 1'b0;
      err      <= 1'b0;
      lfsr     <= LFSR_SEED;
    end else begin
      mode     <= mode_nx;
      eng      <= eng_nx;
      tmr      <= tmr_nx;
      move_cnt <= cnt_nx;
      move_out <= mv_nx;
      prev_sh  <= prev_sh_nx;
      retain   <= retain_nx;
      err      <= err || (push && sol_move >= 4'd12);
      lfsr     <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
endmodule
